bin2seg_display: RTL and testbench

//  Downstream consumer of the sequential divider.
//  - Accepts a binary result (quotient/remainder) with a start pulse, normally the divider's done.
//  - Converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
//  - Drives DIGITS seven-segment digits (ss0..ssN) with leading-zero blanking.
//  - Holds the last displayed result until the next conversion completes.

---
 rtl/bin2seg_display_if.sv | 16 +
 rtl/bin2seg_display.sv | 150 +++++++++++++++
 tb/tb_bin2seg_display.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bin2seg_display_if.sv
// Result-display bus: start/value from the producer, BCD and segment image back.
interface bin2seg_display_if #(
    parameter int WIDTH  = 19,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd;
    logic [8*DIGITS-1:0]   seg;

    modport master (output start, value, input busy, done, ovf, bcd, seg);
    modport slave  (input start, value, output busy, done, ovf, bcd, seg);
endinterface

// File: rtl/bin2seg_display.sv
// Binary-to-BCD (sequential double-dabble) converter driving seven-segment digits
// with optional leading-zero blanking; outputs hold until the next conversion.
module bin2seg_display #(
    parameter int WIDTH  = 19,
    parameter int DIGITS = 6,
    parameter int BLANK  = 1
) (
    input  logic             clk,
    input  logic             RST,
    bin2seg_display_if.slave bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_shift, w_shift_nxt;
    logic [SW-1:0]       r_scratch, w_scratch_nxt, w_adj;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic                r_ovf_int, w_ovf_int_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [SW-1:0]       r_bcd, w_bcd_nxt;
    logic [8*DIGITS-1:0] r_seg, w_seg_nxt, w_seg_img;
    logic                w_seen;
    logic [3:0]          w_dig;

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 8'h3F;
            4'd1:    f_seg = 8'h06;
            4'd2:    f_seg = 8'h5B;
            4'd3:    f_seg = 8'h4F;
            4'd4:    f_seg = 8'h66;
            4'd5:    f_seg = 8'h6D;
            4'd6:    f_seg = 8'h7D;
            4'd7:    f_seg = 8'h07;
            4'd8:    f_seg = 8'h7F;
            4'd9:    f_seg = 8'h6F;
            default: f_seg = 8'h00;
        endcase
    endfunction

    // Add-3 correction on every nibble >= 5, ahead of the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
        end
    end

    // Segment image scanned from the top digit down; digit 0 is never blanked.
    always_comb begin
        w_seg_img = '0;
        w_seen    = 1'b0;
        w_dig     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_dig = r_scratch[4*(DIGITS-1-i) +: 4];
            if (w_dig != 4'd0)
                w_seen = 1'b1;
            if (r_ovf_int)
                w_seg_img[8*(DIGITS-1-i) +: 8] = 8'h40;
            else if (BLANK != 0 && !w_seen && i != DIGITS - 1)
                w_seg_img[8*(DIGITS-1-i) +: 8] = 8'h00;
            else
                w_seg_img[8*(DIGITS-1-i) +: 8] = f_seg(w_dig);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_ovf_int_nxt = r_ovf_int;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ovf_nxt     = r_ovf;
        w_bcd_nxt     = r_bcd;
        w_seg_nxt     = r_seg;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_shift_nxt   = bus.value;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_ovf_int_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_scratch_nxt, w_shift_nxt} = {w_adj, r_shift} << 1;
                w_ovf_int_nxt = r_ovf_int | w_adj[SW-1];
                w_cnt_nxt     = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1))
                    w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                w_bcd_nxt   = r_scratch;
                w_ovf_nxt   = r_ovf_int;
                w_seg_nxt   = w_seg_img;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
            r_seg     <= '0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf_int <= w_ovf_int_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
            r_bcd     <= w_bcd_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.bcd  = r_bcd;
    assign bus.seg  = r_seg;
endmodule

// File: tb/tb_bin2seg_display.sv
// Directed bench for bin2seg_display: a 6-digit blanking instance and a 4-digit unblanked one.
module tb_bin2seg_display;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    int   dones;
    int   done_cyc;

    always #5 clk = ~clk;

    bin2seg_display_if #(.WIDTH(19), .DIGITS(6)) bus6 ();
    bin2seg_display_if #(.WIDTH(19), .DIGITS(4)) bus4 ();

    bin2seg_display #(.WIDTH(19), .DIGITS(6), .BLANK(1)) dut6 (
        .clk(clk), .RST(RST), .bus(bus6)
    );
    bin2seg_display #(.WIDTH(19), .DIGITS(4), .BLANK(0)) dut4 (
        .clk(clk), .RST(RST), .bus(bus4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge following the accepting edge (cycle count 1).
    task automatic go6(input logic [18:0] v);
        @(negedge clk);
        bus6.start = 1'b1;
        bus6.value = v;
        @(negedge clk);
        bus6.start = 1'b0;
    endtask

    task automatic go4(input logic [18:0] v);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.value = v;
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic wait6(output int c);
        c = 1;
        while (!bus6.done && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait4(output int c);
        c = 1;
        while (!bus4.done && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        bus6.start = 1'b0;
        bus6.value = '0;
        bus4.start = 1'b0;
        bus4.value = '0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_seg",  bus6.seg,  48'h0);
        chk("rst_bcd",  bus6.bcd,  24'h0);
        chk("rst_busy", bus6.busy, 1'b0);
        chk("rst_done", bus6.done, 1'b0);
        chk("rst_ovf",  bus6.ovf,  1'b0);
        chk("rst_seg4", bus4.seg,  32'h0);

        // Value 0: done after edge WIDTH+1, i.e. at bench cycle 21
        go6(19'd0);
        chk("zero_busy", bus6.busy, 1'b1);
        wait6(cyc);
        chk("zero_lat", cyc, 21);
        chk("zero_bcd", bus6.bcd, 24'h000000);
        chk("zero_seg", bus6.seg, 48'h00000000003F);
        @(negedge clk);
        chk("zero_done_pulse", bus6.done, 1'b0);
        chk("zero_busy_end",   bus6.busy, 1'b0);

        // Maximum 19-bit value
        go6(19'd524287);
        wait6(cyc);
        chk("max_lat", cyc, 21);
        chk("max_bcd", bus6.bcd, 24'h524287);
        chk("max_seg", bus6.seg, 48'h6D5B665B7F07);
        chk("max_ovf", bus6.ovf, 1'b0);

        // Starts during SHIFT (edges 3, 19) and FINISH (edge 20) are ignored
        @(negedge clk);
        bus6.start = 1'b1;
        bus6.value = 19'd137260;
        @(negedge clk);
        dones    = 0;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus6.done) begin
                dones++;
                done_cyc = c;
            end
            bus6.start = (c == 3 || c == 19 || c == 20);
            bus6.value = 19'd999;
            @(negedge clk);
        end
        bus6.start = 1'b0;
        chk("ign_dones",    dones, 1);
        chk("ign_done_cyc", done_cyc, 21);
        chk("ign_bcd",      bus6.bcd, 24'h137260);
        chk("ign_seg",      bus6.seg, 48'h064F075B7D3F);

        // Reset mid-conversion clears held outputs and aborts
        go6(19'd99999);
        repeat (9) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        chk("mid_rst_bcd",  bus6.bcd,  24'h0);
        chk("mid_rst_seg",  bus6.seg,  48'h0);
        chk("mid_rst_busy", bus6.busy, 1'b0);
        chk("mid_rst_ovf",  bus6.ovf,  1'b0);
        RST = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus6.done) dones++;
            @(negedge clk);
        end
        chk("mid_rst_nodone", dones, 0);
        go6(19'd99999);
        wait6(cyc);
        chk("after_rst_lat", cyc, 21);
        chk("after_rst_bcd", bus6.bcd, 24'h099999);
        chk("after_rst_seg", bus6.seg, 48'h006F6F6F6F6F);

        // Start held high: back-to-back conversions, value resampled each time
        @(negedge clk);
        bus6.start = 1'b1;
        bus6.value = 19'd5;
        @(negedge clk);
        bus6.value = 19'd42;
        wait6(cyc);
        chk("held_lat1", cyc, 21);
        chk("held_bcd1", bus6.bcd, 24'h000005);
        @(negedge clk);
        wait6(cyc);
        chk("held_lat2", cyc + 1, 22);
        chk("held_bcd2", bus6.bcd, 24'h000042);
        chk("held_seg2", bus6.seg, 48'h00000000665B);
        bus6.start = 1'b0;

        // Four digits, no blanking: overflow and boundary
        go4(19'd12345);
        wait4(cyc);
        chk("d4_ovf_lat", cyc, 21);
        chk("d4_ovf",     bus4.ovf, 1'b1);
        chk("d4_ovf_seg", bus4.seg, 32'h40404040);
        go4(19'd9999);
        wait4(cyc);
        chk("d4_9999_ovf", bus4.ovf, 1'b0);
        chk("d4_9999_seg", bus4.seg, 32'h6F6F6F6F);
        chk("d4_9999_bcd", bus4.bcd, 16'h9999);
        go4(19'd7);
        wait4(cyc);
        chk("d4_7_seg", bus4.seg, 32'h3F3F3F07);
        chk("d4_7_bcd", bus4.bcd, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
